// File: rtl/router_out_arbiter.sv
// router_out_arbiter
// Round-robin arbiter plus single-entry output register for one output port
// of a mesh router. Each input offers a single-flit packet on a valid/ready
// handshake. One requester is granted per cycle, its packet is captured, and
// the captured packet is presented on the output handshake one cycle later.
// A full register that drains in the same cycle it accepts keeps one packet
// per cycle flowing.
//
// Optional feature macro: ARB_LOCAL_PRIO_EN
//   defined   -> port 0 (Local) has strict priority and its grants leave the
//                round-robin pointer untouched
//   undefined -> pure round-robin over all ports
//
// Ports
//   clk, rst_n        clock, asynchronous active-low reset
//   req_valid         per-input packet valid                    [NUM_PORTS]
//   req_ready         per-input ready, one-hot or zero (comb)   [NUM_PORTS]
//   req_s_delta_x/y   per-input signed-delta flags              [NUM_PORTS]
//   req_dest_x/y      per-input destination, port i at [i*CW +: CW]
//   req_data          per-input data, port i at [i*DATA_WIDTH +: DATA_WIDTH]
//   out_valid         output packet valid (registered)
//   out_ready         downstream ready
//   out_s_delta_x/y   registered packet flags
//   out_dest_x/y      registered destination                    [CW]
//   out_data          registered data                           [DATA_WIDTH]
//   grant_idx         index of the last accepted port (debug)   [PW]

package global_params;
    localparam int unsigned MESH_SIDE  = 4;
    localparam int unsigned DATA_WIDTH = 8;
endpackage

module router_out_arbiter #(
    parameter  int unsigned NUM_PORTS  = 5,
    parameter  int unsigned MESH_SIDE  = global_params::MESH_SIDE,
    parameter  int unsigned DATA_WIDTH = global_params::DATA_WIDTH,
    localparam int unsigned CW         = (MESH_SIDE > 1) ? $clog2(MESH_SIDE) : 1,
    localparam int unsigned PW         = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_PORTS-1:0]            req_valid,
    output logic [NUM_PORTS-1:0]            req_ready,
    input  logic [NUM_PORTS-1:0]            req_s_delta_x,
    input  logic [NUM_PORTS-1:0]            req_s_delta_y,
    input  logic [NUM_PORTS*CW-1:0]         req_dest_x,
    input  logic [NUM_PORTS*CW-1:0]         req_dest_y,
    input  logic [NUM_PORTS*DATA_WIDTH-1:0] req_data,
    output logic                            out_valid,
    input  logic                            out_ready,
    output logic                            out_s_delta_x,
    output logic                            out_s_delta_y,
    output logic [CW-1:0]                   out_dest_x,
    output logic [CW-1:0]                   out_dest_y,
    output logic [DATA_WIDTH-1:0]           out_data,
    output logic [PW-1:0]                   grant_idx
);

    typedef enum logic {
        ST_EMPTY = 1'b0,
        ST_FULL  = 1'b1
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;
    logic [PW-1:0]         r_ptr;
    logic [PW-1:0]         w_ptr_nxt;
    logic [PW-1:0]         r_grant;
    logic [PW-1:0]         w_grant_nxt;
    logic [PW-1:0]         w_winner;
    logic                  w_found;
    logic                  w_accept;
    logic                  w_load;
    int unsigned           w_scan;

    logic                  r_s_delta_x;
    logic                  r_s_delta_y;
    logic [CW-1:0]         r_dest_x;
    logic [CW-1:0]         r_dest_y;
    logic [DATA_WIDTH-1:0] r_data;

    // Per-port views of the flattened request fields
    logic [CW-1:0]         w_dest_x [NUM_PORTS];
    logic [CW-1:0]         w_dest_y [NUM_PORTS];
    logic [DATA_WIDTH-1:0] w_data   [NUM_PORTS];

    for (genvar g = 0; g < NUM_PORTS; g++) begin : g_unpack
        assign w_dest_x[g] = req_dest_x[g*CW +: CW];
        assign w_dest_y[g] = req_dest_y[g*CW +: CW];
        assign w_data[g]   = req_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Winner select: first valid port scanning from ptr with wrap-around
    always_comb begin
        w_winner = '0;
        w_found  = 1'b0;
        w_scan   = 0;
        for (int unsigned k = 0; k < NUM_PORTS; k++) begin
            w_scan = 32'(r_ptr) + k;
            if (w_scan >= NUM_PORTS) begin
                w_scan = w_scan - NUM_PORTS;
            end
            if (!w_found && req_valid[PW'(w_scan)]) begin
                w_found  = 1'b1;
                w_winner = PW'(w_scan);
            end
        end
`ifdef ARB_LOCAL_PRIO_EN
        // Local port overrides the round-robin choice
        if (req_valid[0]) begin
            w_found  = 1'b1;
            w_winner = '0;
        end
`endif
    end

    // Next-state, pointer/grant update and combinational ready
    always_comb begin
        w_state_nxt = r_state;
        w_ptr_nxt   = r_ptr;
        w_grant_nxt = r_grant;
        req_ready   = '0;

        w_accept = (r_state == ST_EMPTY) || out_ready;
        w_load   = w_found && w_accept;

        // Ready is forced low while reset is held so no upstream handshake completes
        if (rst_n && w_load) begin
            req_ready[w_winner] = 1'b1;
        end

        if (w_load) begin
            w_state_nxt = ST_FULL;
            w_grant_nxt = w_winner;
            w_ptr_nxt   = (w_winner == PW'(NUM_PORTS - 1)) ? '0 : w_winner + PW'(1);
`ifdef ARB_LOCAL_PRIO_EN
            if (w_winner == '0) begin
                w_ptr_nxt = r_ptr;
            end
`endif
        end else if ((r_state == ST_FULL) && out_ready) begin
            w_state_nxt = ST_EMPTY;
        end
    end

    // State, pointer and output packet register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_EMPTY;
            r_ptr       <= '0;
            r_grant     <= '0;
            r_s_delta_x <= 1'b0;
            r_s_delta_y <= 1'b0;
            r_dest_x    <= '0;
            r_dest_y    <= '0;
            r_data      <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_ptr   <= w_ptr_nxt;
            r_grant <= w_grant_nxt;
            if (w_load) begin
                r_s_delta_x <= req_s_delta_x[w_winner];
                r_s_delta_y <= req_s_delta_y[w_winner];
                r_dest_x    <= w_dest_x[w_winner];
                r_dest_y    <= w_dest_y[w_winner];
                r_data      <= w_data[w_winner];
            end
        end
    end

    assign out_valid     = (r_state == ST_FULL);
    assign out_s_delta_x = r_s_delta_x;
    assign out_s_delta_y = r_s_delta_y;
    assign out_dest_x    = r_dest_x;
    assign out_dest_y    = r_dest_y;
    assign out_data      = r_data;
    assign grant_idx     = r_grant;

endmodule
